// File: rtl/tlc_pkg.sv
// Shared traffic-light constants: farm/highway light encodings and the
// farm request conditioner FSM states.
package tlc_pkg;

    localparam int unsigned LIGHT_W = 2;
    localparam int unsigned STATE_W = 2;

    // 2'b11 is left unnamed on purpose; consumers treat it as not-green.
    typedef enum logic [LIGHT_W-1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        PENDING = 2'd2,
        SERVING = 2'd3
    } req_state_t;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for asynchronous inputs, cleared by an async active-low reset.
module synchronizer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/farm_request_conditioner.sv
// Turns the bouncy farm-road sensor into a clean, latched request for the
// traffic-light FSM, and measures how long that request has waited.
module farm_request_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned MIN_PRESENCE    = 8,
    parameter int unsigned WAIT_W          = 31,
    parameter int unsigned MAX_WAIT        = 2**30
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 farmSensorRaw,
    input  logic [LIGHT_W-1:0]   farmSignal,
    output logic                 farmRequest,
    output logic                 sensorClean,
    output logic [WAIT_W-1:0]    waitCycles,
    output logic                 waitExceeded,
    output logic [STATE_W-1:0]   state
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PR_W = (MIN_PRESENCE > 1) ? $clog2(MIN_PRESENCE) : 1;

    logic              sensor_sync;
    logic [DB_W-1:0]   db_cnt, db_cnt_next;
    logic              clean_next;
    logic [PR_W-1:0]   pres_cnt, pres_next;
    logic [WAIT_W-1:0] wait_next;
    logic              req_next, exc_next;
    req_state_t        state_q, state_next;

    synchronizer #(.WIDTH(1)) u_sync (
        .Clk  (Clk),
        .Rst  (Rst),
        .din  (farmSensorRaw),
        .dout (sensor_sync)
    );

    // Debounce: the clean level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        db_cnt_next = '0;
        clean_next  = sensorClean;
        if (sensor_sync != sensorClean) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                clean_next = ~sensorClean;
            end else begin
                db_cnt_next = db_cnt + DB_W'(1);
            end
        end
    end

    // Request FSM next state; waitCycles counts every edge spent in PENDING, including the exit edge.
    always_comb begin
        state_next = state_q;
        pres_next  = pres_cnt;
        wait_next  = waitCycles;
        unique case (state_q)
            IDLE: begin
                if (sensorClean) begin
                    state_next = QUALIFY;
                    pres_next  = '0;
                end
            end
            QUALIFY: begin
                if (!sensorClean) begin
                    state_next = IDLE;
                end else if (pres_cnt == PR_W'(MIN_PRESENCE - 1)) begin
                    state_next = PENDING;
                    wait_next  = '0;
                end else begin
                    pres_next = pres_cnt + PR_W'(1);
                end
            end
            PENDING: begin
                if (waitCycles != {WAIT_W{1'b1}}) begin
                    wait_next = waitCycles + WAIT_W'(1);
                end
                if (farmSignal == GREEN) begin
                    state_next = SERVING;
                end
            end
            SERVING: begin
                if (farmSignal != GREEN) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        req_next = (state_next == PENDING);
        exc_next = (state_next == PENDING) && (wait_next >= WAIT_W'(MAX_WAIT));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            db_cnt       <= '0;
            sensorClean  <= 1'b0;
            pres_cnt     <= '0;
            waitCycles   <= '0;
            farmRequest  <= 1'b0;
            waitExceeded <= 1'b0;
            state_q      <= IDLE;
        end else begin
            db_cnt       <= db_cnt_next;
            sensorClean  <= clean_next;
            pres_cnt     <= pres_next;
            waitCycles   <= wait_next;
            farmRequest  <= req_next;
            waitExceeded <= exc_next;
            state_q      <= state_next;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_farm_request_conditioner.sv
// Self-checking bench for farm_request_conditioner: directed vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_farm_request_conditioner;

    localparam int unsigned DEB   = 4;
    localparam int unsigned MINP  = 3;
    localparam int unsigned WW    = 8;
    localparam int unsigned MAXW  = 10;
    localparam int          SATV  = 255;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          farmSensorRaw;
    logic [1:0]    farmSignal;
    logic          farmRequest;
    logic          sensorClean;
    logic [WW-1:0] waitCycles;
    logic          waitExceeded;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_s1, m_s2, m_clean;
    int m_run, m_phase, m_qual_age, m_pend_len;

    typedef struct {
        bit         raw;
        logic [1:0] sig;
        int         n;
        int         e_state;
        int         e_req;
        int         e_clean;
        int         e_wait;
        int         e_exc;
    } vec_t;

    vec_t vecs[18];

    farm_request_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .MIN_PRESENCE    (MINP),
        .WAIT_W          (WW),
        .MAX_WAIT        (MAXW)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .farmSensorRaw (farmSensorRaw),
        .farmSignal    (farmSignal),
        .farmRequest   (farmRequest),
        .sensorClean   (sensorClean),
        .waitCycles    (waitCycles),
        .waitExceeded  (waitExceeded),
        .state         (state)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_clean = 0; m_run = 0;
        m_phase = 0; m_qual_age = 0; m_pend_len = 0;
    endtask

    // One rising edge of the specified behaviour, from the pre-edge inputs.
    task automatic model_step(input bit raw, input logic [1:0] sig);
        bit old_clean;
        bit sample;
        old_clean = m_clean;
        sample    = m_s2;
        case (m_phase)
            0: if (old_clean) begin m_phase = 1; m_qual_age = 0; end
            1: begin
                if (!old_clean) m_phase = 0;
                else begin
                    m_qual_age++;
                    if (m_qual_age >= int'(MINP)) begin m_phase = 2; m_pend_len = 0; end
                end
            end
            2: begin
                m_pend_len++;
                if (sig == 2'b00) m_phase = 3;
            end
            default: if (sig != 2'b00) m_phase = 0;
        endcase
        if (sample != old_clean) begin
            m_run++;
            if (m_run == int'(DEB)) begin m_clean = ~m_clean; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic check_model();
        int ew;
        ew = (m_pend_len > SATV) ? SATV : m_pend_len;
        chk("model_state", 32'(state), 32'(m_phase));
        chk("model_req",   32'(farmRequest), 32'(m_phase == 2));
        chk("model_clean", 32'(sensorClean), 32'(m_clean));
        chk("model_wait",  32'(waitCycles), 32'(ew));
        chk("model_exc",   32'(waitExceeded), 32'((m_phase == 2) && (ew >= int'(MAXW))));
    endtask

    task automatic tick(input bit raw, input logic [1:0] sig);
        farmSensorRaw = raw;
        farmSignal    = sig;
        @(posedge Clk);
        if (Rst) model_step(raw, sig);
        #1;
        check_model();
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset();
        #2;
        Rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_req",   32'(farmRequest), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_wait",  32'(waitCycles), 32'd0);
        tick(farmSensorRaw, farmSignal);
        tick(farmSensorRaw, farmSignal);
        Rst = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b10,   5, 0, 0, 0,   0, 0};
        vecs[1]  = '{1'b1, 2'b10,   1, 0, 0, 1,   0, 0};
        vecs[2]  = '{1'b1, 2'b10,   1, 1, 0, 1,   0, 0};
        vecs[3]  = '{1'b1, 2'b10,   2, 1, 0, 1,   0, 0};
        vecs[4]  = '{1'b1, 2'b10,   1, 2, 1, 1,   0, 0};
        vecs[5]  = '{1'b0, 2'b10,   4, 2, 1, 1,   4, 0};
        vecs[6]  = '{1'b0, 2'b00,   1, 3, 0, 1,   5, 0};
        vecs[7]  = '{1'b0, 2'b00,   3, 3, 0, 0,   5, 0};
        vecs[8]  = '{1'b0, 2'b01,   1, 0, 0, 0,   5, 0};
        vecs[9]  = '{1'b1, 2'b10,   3, 0, 0, 0,   5, 0};
        vecs[10] = '{1'b0, 2'b10,   6, 0, 0, 0,   5, 0};
        vecs[11] = '{1'b1, 2'b10,   6, 0, 0, 1,   5, 0};
        vecs[12] = '{1'b1, 2'b10,   4, 2, 1, 1,   0, 0};
        vecs[13] = '{1'b1, 2'b10,   9, 2, 1, 1,   9, 0};
        vecs[14] = '{1'b1, 2'b10,   1, 2, 1, 1,  10, 1};
        vecs[15] = '{1'b1, 2'b10, 244, 2, 1, 1, 254, 1};
        vecs[16] = '{1'b1, 2'b10,   1, 2, 1, 1, 255, 1};
        vecs[17] = '{1'b1, 2'b10,  50, 2, 1, 1, 255, 1};

        Rst           = 1'b0;
        farmSensorRaw = 1'b1;
        farmSignal    = 2'b10;
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 2'b10);
        chk("reset_req",   32'(farmRequest), 32'd0);
        chk("reset_clean", 32'(sensorClean), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_exc",   32'(waitExceeded), 32'd0);
        Rst = 1'b1;

        for (int v = 0; v < 18; v++) begin
            for (int c = 0; c < vecs[v].n; c++) tick(vecs[v].raw, vecs[v].sig);
            chk($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].e_state));
            chk($sformatf("vec%0d_req", v),   32'(farmRequest), 32'(vecs[v].e_req));
            chk($sformatf("vec%0d_clean", v), 32'(sensorClean), 32'(vecs[v].e_clean));
            chk($sformatf("vec%0d_wait", v),  32'(waitCycles), 32'(vecs[v].e_wait));
            chk($sformatf("vec%0d_exc", v),   32'(waitExceeded), 32'(vecs[v].e_exc));
        end

        async_reset();

        // Entering PENDING with the light already green: one request cycle, then served.
        for (int c = 0; c < 10; c++) tick(1'b1, 2'b00);
        chk("green_entry_state", 32'(state), 32'd2);
        chk("green_entry_req",   32'(farmRequest), 32'd1);
        tick(1'b1, 2'b00);
        chk("green_serve_state", 32'(state), 32'd3);
        chk("green_serve_req",   32'(farmRequest), 32'd0);
        chk("green_serve_wait",  32'(waitCycles), 32'd1);
        // Vehicle still present when the light leaves green is re-qualified.
        tick(1'b1, 2'b10);
        chk("leave_green_idle", 32'(state), 32'd0);
        tick(1'b1, 2'b10);
        chk("requalify_state", 32'(state), 32'd1);

        for (int c = 0; c < 2500; c++) begin
            bit         r;
            logic [1:0] s;
            r = farmSensorRaw;
            s = farmSignal;
            if ($urandom_range(0, 7) == 0) r = ~r;
            if ($urandom_range(0, 15) == 0) s = 2'($urandom_range(0, 3));
            tick(r, s);
            if ($urandom_range(0, 599) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
